// File: rtl/counter4_mon_pkg.sv
// counter4_mon_pkg: shared width, event FSM states and Gray decode for counter4_wrap_monitor
package counter4_mon_pkg;
  localparam int CNT_W = 4;
  typedef enum logic [0:0] {IDLE = 1'b0, PEND = 1'b1} evt_state_e;
  function automatic logic [CNT_W-1:0] gray2bin4(input logic [CNT_W-1:0] g);
    return {g[3], ^g[3:2], ^g[3:1], ^g[3:0]};
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, asynchronous active-low reset
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/counter4_wrap_monitor.sv
// counter4_wrap_monitor: synchronize/filter a foreign 4-bit count, count wraps, report deltas as events
// Define COUNTER4_WRAP_MON_GRAY_EN when q_in is Gray-coded.
module counter4_wrap_monitor
  import counter4_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  q_in,
  input  logic              clr,
  output logic [CNT_W-1:0]  q_sync,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              overflow,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CNT_W-1:0]  evt_delta
);
  localparam logic [3:0] SC = 4'(STABLE_CYCLES);
  logic [CNT_W-1:0] q_s, samp, diff;
  logic [CNT_W-1:0] last_q, last_d, q_sync_q, q_sync_d, delta_q, delta_d;
  logic [2:0] run_q, run_d;
  logic [3:0] run;
  logic [4:0] sum;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic ovf_q, ovf_d, stable, acc, wrap, sat;
  evt_state_e state_q, state_d;
  sync_2ff #(.W(CNT_W)) u_sync (.clk(clk), .rst(rst), .d(q_in), .q(q_s));
`ifdef COUNTER4_WRAP_MON_GRAY_EN
  assign samp = gray2bin4(q_s);
`else
  assign samp = q_s;
`endif
  // run counts consecutive identical samples including the current one
  always_comb begin
    run      = (samp == last_q) ? {1'b0, run_q} + 4'd1 : 4'd1;
    stable   = run >= SC;
    acc      = stable && samp != q_sync_q;
    diff     = samp - q_sync_q;
    wrap     = acc && samp < q_sync_q;
    sat      = &wrap_q;
    sum      = {1'b0, delta_q} + {1'b0, diff};
    last_d   = samp;
    run_d    = run[3] ? 3'd7 : run[2:0];
    q_sync_d = acc ? samp : q_sync_q;
    wrap_d   = clr ? '0 : (wrap && !sat) ? wrap_q + 1'b1 : wrap_q;
    ovf_d    = !clr && (ovf_q || (wrap && sat));
    state_d  = clr ? IDLE : acc ? PEND : (state_q == PEND && evt_ready) ? IDLE : state_q;
    delta_d  = clr ? '0 : !acc ? delta_q :
               (state_q == PEND && !evt_ready) ? (sum[4] ? 4'hF : sum[3:0]) : diff;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last_q   <= '0;
      run_q    <= '0;
      q_sync_q <= '0;
      wrap_q   <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      delta_q  <= '0;
    end else begin
      last_q   <= last_d;
      run_q    <= run_d;
      q_sync_q <= q_sync_d;
      wrap_q   <= wrap_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      delta_q  <= delta_d;
    end
  assign q_sync    = q_sync_q;
  assign wrap_cnt  = wrap_q;
  assign overflow  = ovf_q;
  assign evt_valid = state_q == PEND;
  assign evt_delta = delta_q;
endmodule
